ccff_loader: RTL and testbench
==============================

# ccff_loader

Configuration-chain loader that drives the fabric's `ccff_head` and receives its `ccff_tail`, from the side opposite the routing and logic tiles. It accepts bitstream words over a valid/ready interface and serialises exactly `CHAIN_LEN` bits into the chain. It gates the fabric chain clock so that it shifts only when a bit is ready. It also captures the bits that emerge at `ccff_tail`, which are the previous chain contents, and returns them as readback words for verification.

## Interface
Parameters:
- `CHAIN_LEN`, default 8: total configuration flops in the chain; must be ≥1.
- `WORD_W`, default 32: width of bitstream and readback words; must be ≥1.

Ports:
- `prog_clk`, in, 1: the only clock.
- `prog_reset_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: one-cycle pulse that begins a load; ignored unless the block is IDLE or DONE.
- `cfg_word`, in, `WORD_W`: bitstream word.
- `cfg_valid`, in, 1: `cfg_word` is valid.
- `cfg_ready`, out, 1: the loader accepts `cfg_word` this cycle.
- `rb_word`, out, `WORD_W`: readback word.
- `rb_valid`, out, 1: `rb_word` is valid.
- `rb_ready`, in, 1: the consumer accepts `rb_word`.
- `ccff_head`, out, 1: serial data into the chain; registered.
- `ccff_tail`, in, 1: serial data out of the chain.
- `chain_clk_en`, out, 1: enable for the external clock gate of the fabric `prog_clk`; registered.
- `busy`, out, 1: high in LOAD, SHIFT and FLUSH.
- `done`, out, 1: high in DONE.

## Operation
States are IDLE, LOAD, SHIFT, FLUSH and DONE. The reset state is IDLE.

- **IDLE/DONE.** A `start` pulse clears the bit counter and the readback shift register, then moves to LOAD. From DONE, `start` also clears `done`.
- **LOAD.** `cfg_ready`=1. When `cfg_valid && cfg_ready`, the word is captured and the state moves to SHIFT.
- **SHIFT.** One chain bit per cycle:
  - The captured word is sent MSB first: bit `WORD_W-1` goes first.
  - Each cycle with `chain_clk_en`=1 is one fabric shift.
  - In that cycle the loader samples `ccff_tail` into the LSB of the readback shift register.
- **End of a word.** After `WORD_W` shifts, or when the chain total reaches `CHAIN_LEN`, the state moves to FLUSH.
- **FLUSH.** Holds `rb_valid`=1 until `rb_ready`. Then it goes to LOAD if bits remain, otherwise to DONE.
- **Final partial word.** Applies when `R = CHAIN_LEN mod WORD_W` is nonzero.
  - Only bits `[WORD_W-1 : WORD_W-R]` of the last `cfg_word` are shifted; the lower bits are discarded.
  - The last `rb_word` holds the R captured bits left-aligned in `[WORD_W-1 : WORD_W-R]`, with the lower bits set to 0.
- **Chain ordering.** After a complete load, the chain flop adjacent to `ccff_tail` holds the first bit shifted.
- **Readback.** Readback word k holds chain bits k·`WORD_W` onward, counted from the tail end, before the load. A second identical load therefore reads back the first bitstream exactly.
- **Word count.** Total words are `ceil(CHAIN_LEN/WORD_W)` in each direction.
- **No stall mid-word.** Once in SHIFT, the loader completes the word on consecutive cycles.
- **Stalls between words.**
  - Starvation (`cfg_valid`=0 in LOAD) and backpressure (`rb_ready`=0 in FLUSH) only add cycles with `chain_clk_en`=0.
  - No bit is lost or duplicated.
- **Reset mid-operation.** Asynchronously clears every output. Chain contents are then undefined, and software must restart.

## Timing
- **Registered outputs.** `ccff_head` and `chain_clk_en` are registered and change together. In a cycle where `chain_clk_en`=1, the fabric captures `ccff_head` at the next rising edge.
- **Tail sampling.** `ccff_tail` is sampled at that same edge, so the captured value is the pre-shift tail bit.
- **Latency.**
  - The first `chain_clk_en`=1 occurs in the cycle after the `cfg_valid && cfg_ready` handshake.
  - Back-to-back throughput is `WORD_W` shift cycles plus 2 cycles per word: the LOAD handshake cycle and the FLUSH cycle with `rb_ready`=1.
- **Reset values.** `cfg_ready`=0, `rb_valid`=0, `rb_word`=0, `ccff_head`=0, `chain_clk_en`=0, `busy`=0, `done`=0.
- **Handshake rules.**
  - `rb_word` is stable while `rb_valid && !rb_ready`.
  - `cfg_ready` depends only on state, never combinationally on `cfg_valid`.
- **Simultaneous events.** A `start` during `busy` has no effect.
- **Counter widths.** The bit counter is `$clog2(CHAIN_LEN+1)` bits wide. The in-word counter is `$clog2(WORD_W+1)` bits wide. Neither counter wraps: both saturate at their terminal values.

## Structure
- The shared package holds the state enum `ccff_ld_state_t` and the derived-width helper functions.
- One sub-module, `ccff_serdes`, contains the `WORD_W` parallel-to-serial register and the serial-to-parallel register, with load, shift and clear controls.
- The top level holds the FSM, both counters and the handshake logic.

## Test plan
Directed scenarios, each stimulus followed by the required response:
- **Single-word load.** `CHAIN_LEN`=8, `WORD_W`=8, behavioural chain preloaded to 0x3C. Load 0xA5 → `rb_word`=0x3C. The chain reads back 0xA5 on a second load, and `done`=1 after 10 cycles plus the handshakes.
- **Partial last word.** `CHAIN_LEN`=20, `WORD_W`=8. Feed words 0x12, 0x34, 0x5F → 20 enabled shifts in total; the final word contributes only nibble 0x5. The third `rb_word` has its low nibble = 0.
- **Input starvation.** Drop `cfg_valid` for 5 cycles between words → `chain_clk_en`=0 for those cycles, and the bit count is unchanged.
- **Readback backpressure.** Hold `rb_ready`=0 for 7 cycles → `rb_word` is stable, no shifts occur, and loading resumes after release.
- **Reset mid-operation.** Assert `prog_reset_n`=0 in the middle of SHIFT → all outputs go to 0 immediately. A new `start` performs a full `CHAIN_LEN` load.
- **Start while busy.** Assert `start` during `busy` → ignored. The total enabled shift count equals `CHAIN_LEN`.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and width helpers for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } ccff_ld_state_t;

    // Width of a counter that must reach chain_len inclusive.
    function automatic int bit_cnt_w(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    // Width of a counter that must reach word_w inclusive.
    function automatic int word_cnt_w(input int word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/ccff_serdes.sv
// Word-wide serialiser feeding ccff_head and deserialiser collecting ccff_tail.
module ccff_serdes #(
    parameter int WORD_W = 32
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              load,
    input  logic [WORD_W-1:0] par_in,
    input  logic              advance,
    input  logic              park,
    output logic              ser_out,
    input  logic              clear,
    input  logic              sample,
    input  logic              ser_in,
    output logic [WORD_W-1:0] par_out
);

    logic [WORD_W-1:0] piso;
    logic [WORD_W-1:0] sipo;

    // Parallel-to-serial: MSB goes out first; ser_out is the registered head bit.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            piso    <= '0;
            ser_out <= 1'b0;
        end else if (load) begin
            ser_out <= par_in[WORD_W-1];
            piso    <= par_in << 1;
        end else if (advance) begin
            ser_out <= piso[WORD_W-1];
            piso    <= piso << 1;
        end else if (park) begin
            ser_out <= 1'b0;
        end
    end

    // Serial-to-parallel: each tail bit enters at the LSB, first bit ends at the MSB.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            sipo <= '0;
        end else if (clear) begin
            sipo <= '0;
        end else if (sample) begin
            sipo <= (sipo << 1) | WORD_W'(ser_in);
        end
    end

    assign par_out = sipo;

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: streams bitstream words into ccff_head with a
// gated chain clock and returns the displaced chain contents as readback words.
module ccff_loader #(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done
);
    import ccff_loader_pkg::*;

    localparam int BC_W = bit_cnt_w(CHAIN_LEN);
    localparam int WC_W = word_cnt_w(WORD_W);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(CHAIN_LEN - 1);
    localparam logic [BC_W-1:0] BIT_END   = BC_W'(CHAIN_LEN);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WORD_W - 1);
    localparam logic [WC_W-1:0] WORD_END  = WC_W'(WORD_W);

    ccff_ld_state_t    state, state_next;
    logic [BC_W-1:0]   bit_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic [WC_W-1:0]   align;
    logic [WORD_W-1:0] rb_raw;
    logic              start_ok;
    logic              cfg_hs;
    logic              shifting;
    logic              last_bit;

    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    assign cfg_hs   = cfg_valid && cfg_ready;
    assign shifting = (state == ST_SHIFT);
    assign last_bit = shifting && (word_cnt == WORD_LAST || bit_cnt == BIT_LAST);

    // State register.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) state <= ST_IDLE;
        else               state <= state_next;
    end

    // Next-state and state-decoded handshake/status outputs.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        rb_valid   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (cfg_valid) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                rb_valid = 1'b1;
                busy     = 1'b1;
                if (rb_ready) state_next = (bit_cnt == BIT_END) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_next = ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Saturating bit/in-word counters and the registered chain clock enable.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            bit_cnt      <= '0;
            word_cnt     <= '0;
            chain_clk_en <= 1'b0;
        end else begin
            if (start_ok)
                bit_cnt <= '0;
            else if (shifting && bit_cnt != BIT_END)
                bit_cnt <= bit_cnt + BC_W'(1);

            if (cfg_hs)
                word_cnt <= '0;
            else if (shifting && word_cnt != WORD_END)
                word_cnt <= word_cnt + WC_W'(1);

            chain_clk_en <= cfg_hs || (shifting && !last_bit);
        end
    end

    ccff_serdes #(
        .WORD_W (WORD_W)
    ) u_serdes (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .load         (cfg_hs),
        .par_in       (cfg_word),
        .advance      (shifting && !last_bit),
        .park         (last_bit),
        .ser_out      (ccff_head),
        .clear        (start_ok || cfg_hs),
        .sample       (shifting),
        .ser_in       (ccff_tail),
        .par_out      (rb_raw)
    );

    // A partial final word leaves its captured bits low; shift them up to the MSB end.
    assign align   = WORD_END - word_cnt;
    assign rb_word = rb_raw << align;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench: an 8/8 instance for the single-word case and a 20/8 instance
// for partial words, stalls, start-while-busy and mid-shift reset.
module tb_ccff_loader;

    localparam int SL = 8;
    localparam int BL = 20;
    localparam int W  = 8;

    logic prog_clk = 1'b0;
    logic prog_reset_n = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // small instance
    logic          start_s, cfg_valid_s, cfg_ready_s, rb_valid_s, rb_ready_s;
    logic [W-1:0]  cfg_word_s, rb_word_s;
    logic          head_s, tail_s, en_s, busy_s, done_s;
    // big instance
    logic          start_b, cfg_valid_b, cfg_ready_b, rb_valid_b, rb_ready_b;
    logic [W-1:0]  cfg_word_b, rb_word_b;
    logic          head_b, tail_b, en_b, busy_b, done_b;

    ccff_loader #(.CHAIN_LEN(SL), .WORD_W(W)) u_small (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start_s),
        .cfg_word(cfg_word_s), .cfg_valid(cfg_valid_s), .cfg_ready(cfg_ready_s),
        .rb_word(rb_word_s), .rb_valid(rb_valid_s), .rb_ready(rb_ready_s),
        .ccff_head(head_s), .ccff_tail(tail_s), .chain_clk_en(en_s),
        .busy(busy_s), .done(done_s)
    );

    ccff_loader #(.CHAIN_LEN(BL), .WORD_W(W)) u_dut (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start_b),
        .cfg_word(cfg_word_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .rb_word(rb_word_b), .rb_valid(rb_valid_b), .rb_ready(rb_ready_b),
        .ccff_head(head_b), .ccff_tail(tail_b), .chain_clk_en(en_b),
        .busy(busy_b), .done(done_b)
    );

    // Behavioural fabric chains: index 0 is next to ccff_head, top index next to ccff_tail.
    logic [SL-1:0] chain_s = '0;
    logic [BL-1:0] chain_b = '0;
    logic          pre_s = 1'b0, pre_b = 1'b0;
    logic [SL-1:0] pre_val_s = '0;
    logic [BL-1:0] pre_val_b = '0;
    int            shifts_s = 0, shifts_b = 0;

    always @(posedge prog_clk) begin
        if (pre_s)     chain_s <= pre_val_s;
        else if (en_s) chain_s <= {chain_s[SL-2:0], head_s};
        if (pre_b)     chain_b <= pre_val_b;
        else if (en_b) chain_b <= {chain_b[BL-2:0], head_b};
        if (en_s) shifts_s <= shifts_s + 1;
        if (en_b) shifts_b <= shifts_b + 1;
    end
    assign tail_s = chain_s[SL-1];
    assign tail_b = chain_b[BL-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_b(input logic [W-1:0] w);
        cfg_word_b  = w;
        cfg_valid_b = 1'b1;
        for (int i = 0; i < 40 && !cfg_ready_b; i++) @(negedge prog_clk);
        chk("cfg_ready_wait", 32'(cfg_ready_b), 32'd1);
        @(negedge prog_clk);
        cfg_valid_b = 1'b0;
    endtask

    task automatic get_rb_b(output logic [W-1:0] w);
        rb_ready_b = 1'b1;
        for (int i = 0; i < 40 && !rb_valid_b; i++) @(negedge prog_clk);
        chk("rb_valid_wait", 32'(rb_valid_b), 32'd1);
        w = rb_word_b;
        @(negedge prog_clk);
        rb_ready_b = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready_b), 32'd0);
        chk({tag, "_rb_valid"},  32'(rb_valid_b),  32'd0);
        chk({tag, "_rb_word"},   32'(rb_word_b),   32'd0);
        chk({tag, "_head"},      32'(head_b),      32'd0);
        chk({tag, "_clk_en"},    32'(en_b),        32'd0);
        chk({tag, "_busy"},      32'(busy_b),      32'd0);
        chk({tag, "_done"},      32'(done_b),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] got;
        int cyc;
        int base;

        start_s = 0; cfg_word_s = '0; cfg_valid_s = 0; rb_ready_s = 0;
        start_b = 0; cfg_word_b = '0; cfg_valid_b = 0; rb_ready_b = 0;

        repeat (2) @(negedge prog_clk);
        chk_outputs_zero("reset");
        chk("reset_s_busy", 32'(busy_s), 32'd0);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);

        pre_val_s = 8'h3C; pre_val_b = 20'hABCDE;
        pre_s = 1'b1; pre_b = 1'b1;
        @(negedge prog_clk);
        pre_s = 1'b0; pre_b = 1'b0;

        // Single-word load, held valid/ready: done 10 cycles after the start edge.
        for (int pass = 0; pass < 2; pass++) begin
            cfg_word_s  = (pass == 0) ? 8'hA5 : 8'h00;
            cfg_valid_s = 1'b1;
            rb_ready_s  = 1'b1;
            start_s     = 1'b1;
            @(negedge prog_clk);
            start_s = 1'b0;
            chk("s_load_ready", 32'(cfg_ready_s), 32'd1);
            chk("s_load_en",    32'(en_s),        32'd0);
            cyc = 0;
            got = '0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge prog_clk);
                cyc = i;
                if (i == 1) begin
                    chk("s_first_en",   32'(en_s),   32'd1);
                    chk("s_first_head", 32'(head_s), 32'(cfg_word_s[W-1]));
                end
                if (rb_valid_s) got = rb_word_s;
                if (done_s) break;
            end
            chk("s_done_latency", 32'(cyc), 32'd10);
            chk("s_rb_word", 32'(got), (pass == 0) ? 32'h3C : 32'hA5);
            chk("s_chain",   32'(chain_s), (pass == 0) ? 32'hA5 : 32'h00);
            chk("s_shifts",  32'(shifts_s), (pass == 0) ? 32'd8 : 32'd16);
            cfg_valid_s = 1'b0;
            rb_ready_s  = 1'b0;
            @(negedge prog_clk);
        end

        // Partial last word with starvation and backpressure.
        start_b = 1'b1;
        @(negedge prog_clk);
        start_b = 1'b0;
        send_b(8'h12);
        get_rb_b(w);
        chk("b_rb0", 32'(w), 32'hAB);
        chk("b_shifts0", 32'(shifts_b), 32'd8);

        for (int i = 0; i < 5; i++) begin
            start_b = (i == 2);
            @(negedge prog_clk);
            chk("starve_en",    32'(en_b),        32'd0);
            chk("starve_ready", 32'(cfg_ready_b), 32'd1);
        end
        start_b = 1'b0;
        chk("starve_shifts", 32'(shifts_b), 32'd8);

        send_b(8'h34);
        for (int i = 0; i < 40 && !rb_valid_b; i++) @(negedge prog_clk);
        chk("bp_valid", 32'(rb_valid_b), 32'd1);
        for (int i = 0; i < 7; i++) begin
            start_b = (i == 3);
            @(negedge prog_clk);
            chk("bp_word",  32'(rb_word_b),  32'hCD);
            chk("bp_valid", 32'(rb_valid_b), 32'd1);
            chk("bp_en",    32'(en_b),       32'd0);
        end
        start_b = 1'b0;
        chk("bp_shifts", 32'(shifts_b), 32'd16);
        rb_ready_b = 1'b1;
        @(negedge prog_clk);
        rb_ready_b = 1'b0;
        chk("bp_resume", 32'(cfg_ready_b), 32'd1);

        send_b(8'h5F);
        get_rb_b(w);
        chk("b_rb2_partial", 32'(w), 32'hE0);
        chk("b_shifts_total", 32'(shifts_b), 32'd20);
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_busy_done", 32'(busy_b), 32'd0);
        chk("b_chain", 32'(chain_b), 32'h12345);

        // Identical second load reads back the first bitstream.
        start_b = 1'b1;
        @(negedge prog_clk);
        start_b = 1'b0;
        chk("b2_done_cleared", 32'(done_b), 32'd0);
        send_b(8'h12); get_rb_b(w); chk("b2_rb0", 32'(w), 32'h12);
        send_b(8'h34); get_rb_b(w); chk("b2_rb1", 32'(w), 32'h34);
        send_b(8'h5F); get_rb_b(w); chk("b2_rb2", 32'(w), 32'h50);
        chk("b2_chain", 32'(chain_b), 32'h12345);
        chk("b2_shifts", 32'(shifts_b), 32'd40);

        // Reset in the middle of SHIFT.
        start_b = 1'b1;
        @(negedge prog_clk);
        start_b = 1'b0;
        send_b(8'hFF);
        @(negedge prog_clk);
        chk("mid_shift_en", 32'(en_b), 32'd1);
        #1 prog_reset_n = 1'b0;
        #1 chk_outputs_zero("async_rst");
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);

        base = shifts_b;
        start_b = 1'b1;
        @(negedge prog_clk);
        start_b = 1'b0;
        send_b(8'hC3); get_rb_b(w);
        send_b(8'h3C); get_rb_b(w);
        send_b(8'hA0); get_rb_b(w);
        chk("rst_reload_shifts", 32'(shifts_b - base), 32'd20);
        chk("rst_reload_done",   32'(done_b), 32'd1);
        chk("rst_reload_chain",  32'(chain_b), 32'hC33CA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
